// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared widths and FSM state encodings for the serial loopback link
package serial_pkg;

   localparam int PACKET_W = 42;
   localparam int PAD_W    = 4;
   localparam int FRAME_W  = PAD_W + PACKET_W;

   typedef logic [1:0] tx_state_t;
   localparam tx_state_t TX_IDLE  = 2'd0;
   localparam tx_state_t TX_START = 2'd1;
   localparam tx_state_t TX_DATA  = 2'd2;
   localparam tx_state_t TX_STOP  = 2'd3;

   typedef logic [1:0] rx_state_t;
   localparam rx_state_t RX_IDLE = 2'd0;
   localparam rx_state_t RX_DATA = 2'd1;
   localparam rx_state_t RX_STOP = 2'd2;

endpackage

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - serial-to-parallel deframer with stop-bit check and sticky valid
module serial_rx
   import serial_pkg::*;
#(
   parameter int W = serial_pkg::FRAME_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         line,
   input  logic         flush,
   output logic         valid,
   output logic [W-1:0] word
);

   localparam int CNT_W = $clog2(W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

   rx_state_t        state;
   logic [W-1:0]     shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic             frame_done;

   assign frame_done = (state == RX_STOP) && line;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RX_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         valid   <= 1'b0;
         word    <= '0;
      end else begin
         case (state)
            RX_IDLE: begin
               if (!line) begin
                  bit_cnt <= '0;
                  state   <= RX_DATA;
               end
            end
            RX_DATA: begin
               shreg <= {line, shreg[W-1:1]};
               if (bit_cnt == LAST_BIT) state <= RX_STOP;
               else bit_cnt <= bit_cnt + 1'b1;
            end
            RX_STOP: begin
               // a low stop bit is a framing error: drop the frame silently
               if (line) word <= shreg;
               state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase

         if (frame_done) valid <= 1'b1;
         else if (flush) valid <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-to-serial framer: start bit, W data bits LSB first, stop bit
module serial_tx
   import serial_pkg::*;
#(
   parameter int W = serial_pkg::FRAME_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [W-1:0] word,
   output logic         ack,
   output logic         line
);

   localparam int CNT_W = $clog2(W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

   tx_state_t        state;
   logic [W-1:0]     shreg;
   logic [CNT_W-1:0] bit_cnt;

   // STOP accepts the next word directly so held-enable frames run back-to-back
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= TX_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         line    <= 1'b1;
         ack     <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (state)
            TX_IDLE, TX_STOP: begin
               if (enable) begin
                  shreg <= word;
                  ack   <= 1'b1;
                  line  <= 1'b0;
                  state <= TX_START;
               end else begin
                  line  <= 1'b1;
                  state <= TX_IDLE;
               end
            end
            TX_START: begin
               line    <= shreg[0];
               shreg   <= shreg >> 1;
               bit_cnt <= '0;
               state   <= TX_DATA;
            end
            TX_DATA: begin
               if (bit_cnt == LAST_BIT) begin
                  line  <= 1'b1;
                  state <= TX_STOP;
               end else begin
                  line    <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: begin
               line  <= 1'b1;
               state <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/top_serial.sv
// rtl/top_serial.sv - loopback link: serial_tx and serial_rx joined by an internal 1-bit line
module top_serial #(
   parameter int PACKET_W = serial_pkg::PACKET_W,
   parameter int PAD_W    = serial_pkg::PAD_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PAD_W-1:0]    sender_padding,
   input  logic [PACKET_W-1:0] sender_packet,
   input  logic                sender_enable,
   output logic                sender_ack,
   input  logic                flush,
   output logic                receiver_valid,
   output logic [PAD_W-1:0]    receiver_padding,
   output logic [PACKET_W-1:0] receiver_packet
);

   localparam int W = PAD_W + PACKET_W;

   logic         serial_line;
   logic [W-1:0] rx_word;

   serial_tx #(.W(W)) u_tx (
      .clk    (clk),
      .rst    (rst),
      .enable (sender_enable),
      .word   ({sender_padding, sender_packet}),
      .ack    (sender_ack),
      .line   (serial_line)
   );

   serial_rx #(.W(W)) u_rx (
      .clk   (clk),
      .rst   (rst),
      .line  (serial_line),
      .flush (flush),
      .valid (receiver_valid),
      .word  (rx_word)
   );

   assign receiver_packet  = rx_word[PACKET_W-1:0];
   assign receiver_padding = rx_word[W-1:PACKET_W];

endmodule

// File: tb/tb_top_serial.sv
// tb/tb_top_serial.sv - directed self-checking bench for top_serial
module tb_top_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  sender_padding;
   logic [41:0] sender_packet;
   logic        sender_enable;
   logic        sender_ack;
   logic        flush;
   logic        receiver_valid;
   logic [3:0]  receiver_padding;
   logic [41:0] receiver_packet;

   int checks   = 0;
   int failures = 0;

   localparam logic [41:0] PKT_A = 42'h2AC19440329;
   localparam logic [41:0] PKT_B = 42'h3FFFFFFFFFF;
   localparam logic [41:0] PKT_C = 42'h15555555555;

   top_serial dut (
      .clk              (clk),
      .rst              (rst),
      .sender_padding   (sender_padding),
      .sender_packet    (sender_packet),
      .sender_enable    (sender_enable),
      .sender_ack       (sender_ack),
      .flush            (flush),
      .receiver_valid   (receiver_valid),
      .receiver_padding (receiver_padding),
      .receiver_packet  (receiver_packet)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      while (sender_ack !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check(tag, 64'(sender_ack), 64'd1);
   endtask

   initial begin
      int seen;
      rst            = 1'b1;
      sender_padding = '0;
      sender_packet  = '0;
      sender_enable  = 1'b0;
      flush          = 1'b0;

      repeat (11) tick();
      check("reset_ack",     64'(sender_ack),       64'd0);
      check("reset_valid",   64'(receiver_valid),   64'd0);
      check("reset_packet",  64'(receiver_packet),  64'd0);
      check("reset_padding", 64'(receiver_padding), 64'd0);
      rst = 1'b0;
      tick();

      // basic transfer, enable held for back-to-back frames
      sender_padding = 4'b1011;
      sender_packet  = PKT_A;
      sender_enable  = 1'b1;
      wait_ack("ack_first");
      tick();
      check("ack_one_cycle", 64'(sender_ack), 64'd0);
      repeat (46) tick();
      check("valid_before_latency", 64'(receiver_valid), 64'd0);
      tick();
      check("valid_at_48",    64'(receiver_valid),   64'd1);
      check("packet_basic",   64'(receiver_packet),  64'(PKT_A));
      check("padding_basic",  64'(receiver_padding), 64'hB);
      check("ack_back2back",  64'(sender_ack),       64'd1);

      // flush while the next frame is in flight
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_clears", 64'(receiver_valid), 64'd0);
      repeat (46) tick();
      check("flush_still_low", 64'(receiver_valid), 64'd0);
      tick();
      check("valid_again",   64'(receiver_valid),  64'd1);
      check("packet_again",  64'(receiver_packet), 64'(PKT_A));
      check("ack_third",     64'(sender_ack),      64'd1);

      // change input after latch: frame 3 keeps old data, frame 4 carries new
      sender_packet = PKT_B;
      repeat (48) tick();
      check("latched_valid",  64'(receiver_valid),  64'd1);
      check("latched_packet", 64'(receiver_packet), 64'(PKT_A));
      check("ack_fourth",     64'(sender_ack),      64'd1);

      // flush in the same cycle frame 4 completes
      repeat (47) tick();
      check("pre_collision_packet", 64'(receiver_packet), 64'(PKT_A));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("collision_valid",   64'(receiver_valid),   64'd1);
      check("collision_packet",  64'(receiver_packet),  64'(PKT_B));
      check("collision_padding", 64'(receiver_padding), 64'hB);
      check("ack_fifth",         64'(sender_ack),       64'd1);

      // reset 20 cycles into frame 5
      sender_enable = 1'b0;
      repeat (20) tick();
      rst = 1'b1;
      tick();
      check("midrst_ack",     64'(sender_ack),       64'd0);
      check("midrst_valid",   64'(receiver_valid),   64'd0);
      check("midrst_packet",  64'(receiver_packet),  64'd0);
      check("midrst_padding", 64'(receiver_padding), 64'd0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (receiver_valid === 1'b1 || sender_ack === 1'b1) seen++;
      end
      check("no_partial_frame", 64'(seen), 64'd0);

      // fresh frame after reset
      sender_padding = 4'b0110;
      sender_packet  = PKT_C;
      sender_enable  = 1'b1;
      wait_ack("ack_fresh");
      sender_enable = 1'b0;
      repeat (47) tick();
      check("fresh_not_yet", 64'(receiver_valid), 64'd0);
      tick();
      check("fresh_valid",   64'(receiver_valid),   64'd1);
      check("fresh_packet",  64'(receiver_packet),  64'(PKT_C));
      check("fresh_padding", 64'(receiver_padding), 64'h6);
      check("fresh_no_ack",  64'(sender_ack),       64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
